mem_controller: RTL and testbench

MEM_CONTROLLER -- requirements
Module: mem_controller

---
 rtl/mc_pkg.sv | 16 +
 rtl/mem_controller_if.sv | 36 +++
 rtl/mem_controller.sv | 88 ++++++++
 tb/tb_mem_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared widths and FSM state type for the SRAM memory controller
package mc_pkg;
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int WORD_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        F_LO,
        F_HI,
        R_LO,
        R_HI,
        W_LO,
        W_HI
    } state_e;
endpackage

// File: rtl/mem_controller_if.sv
// mem_controller_if: pipeline request ports and off-chip SRAM pins of the memory controller
interface mem_controller_if;
    import mc_pkg::*;
    logic               if_mc_en;
    logic [SRAM_AW-1:0] if_mc_addr;
    logic [WORD_W-1:0]  mc_if_data;
    logic               mc_if_valid;
    logic               mem_mc_en;
    logic               mem_mc_rw;
    logic [SRAM_AW-1:0] mem_mc_addr;
    logic [WORD_W-1:0]  mem_mc_wdata;
    logic [WORD_W-1:0]  mc_mem_rdata;
    logic               mc_mem_done;
    logic               mc_stall;
    logic [SRAM_AW-1:0] sram_addr;
    logic [SRAM_DW-1:0] sram_dq_out;
    logic               sram_dq_oe;
    logic [SRAM_DW-1:0] sram_dq_in;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic               sram_we_n;
    logic               sram_ub_n;
    logic               sram_lb_n;

    modport slave (
        input  if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_wdata, sram_dq_in,
        output mc_if_data, mc_if_valid, mc_mem_rdata, mc_mem_done, mc_stall,
               sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport master (
        output if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_wdata, sram_dq_in,
        input  mc_if_data, mc_if_valid, mc_mem_rdata, mc_mem_done, mc_stall,
               sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/mem_controller.sv
// mem_controller: arbitrates fetch and data requests onto a 16-bit SRAM, two halfword cycles per 32-bit word
module mem_controller
    import mc_pkg::*;
(
    input logic              clock,
    input logic              reset,
    mem_controller_if.slave  bus
);
    state_e               state_q, state_d;
    logic [SRAM_AW-3:0]   addr_q;
    logic [WORD_W-1:0]    wdata_q;
    logic [SRAM_DW-1:0]   lo_q;
    logic [WORD_W-1:0]    if_data_q;
    logic [WORD_W-1:0]    mem_rdata_q;
    logic                 if_valid_q;
    logic                 mem_done_q;
    logic                 mem_req;
    logic                 if_req;
    logic                 active;
    logic                 hi;
    logic                 wr;
    logic                 unused_addr_lsbs;

    assign unused_addr_lsbs = ^{bus.if_mc_addr[1:0], bus.mem_mc_addr[1:0]};

    // A requester still holding its level request in its own completion cycle is not served twice
    assign mem_req = bus.mem_mc_en & ~mem_done_q;
    assign if_req  = bus.if_mc_en & ~if_valid_q;

    // Next state: data stage wins arbitration in IDLE, each access is LO then HI then back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = mem_req ? (bus.mem_mc_rw ? W_LO : R_LO) : (if_req ? F_LO : IDLE);
            F_LO:    state_d = F_HI;
            R_LO:    state_d = R_HI;
            W_LO:    state_d = W_HI;
            default: state_d = IDLE;
        endcase
    end

    // State register, forced to IDLE the moment reset asserts
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request latching, halfword capture and result registers with their completion pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            if_valid_q <= state_q == F_HI;
            mem_done_q <= state_q == R_HI || state_q == W_HI;
            if (state_q == IDLE && state_d != IDLE) begin
                addr_q  <= mem_req ? bus.mem_mc_addr[SRAM_AW-1:2] : bus.if_mc_addr[SRAM_AW-1:2];
                wdata_q <= bus.mem_mc_wdata;
            end
            if (state_q == F_LO || state_q == R_LO) lo_q <= bus.sram_dq_in;
            if (state_q == F_HI) if_data_q <= {bus.sram_dq_in, lo_q};
            if (state_q == R_HI) mem_rdata_q <= {bus.sram_dq_in, lo_q};
        end
    end

    assign active = state_q != IDLE;
    assign hi     = state_q == F_HI || state_q == R_HI || state_q == W_HI;
    assign wr     = state_q == W_LO || state_q == W_HI;

    assign bus.sram_addr   = active ? {1'b0, addr_q, hi} : '0;
    assign bus.sram_dq_out = wr ? (hi ? wdata_q[WORD_W-1:SRAM_DW] : wdata_q[SRAM_DW-1:0]) : '0;
    assign bus.sram_dq_oe  = wr;
    assign bus.sram_ce_n   = ~active;
    assign bus.sram_ub_n   = ~active;
    assign bus.sram_lb_n   = ~active;
    assign bus.sram_oe_n   = ~(active & ~wr);
    assign bus.sram_we_n   = ~wr;
    assign bus.mc_stall    = active;
    assign bus.mc_if_data   = if_data_q;
    assign bus.mc_if_valid  = if_valid_q;
    assign bus.mc_mem_rdata = mem_rdata_q;
    assign bus.mc_mem_done  = mem_done_q;
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed and randomized checks of mem_controller against a word-level memory model
module tb_mem_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] sram [0:262143];
    logic [31:0] ref_mem [int];
    logic [31:0] exp_if = '0;
    logic [31:0] exp_rd = '0;

    mem_controller_if bus();

    mem_controller dut (.clock(clk), .reset(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign bus.sram_dq_in = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram[bus.sram_addr] : 16'h0;

    always @(posedge clk) if (!bus.sram_ce_n && !bus.sram_we_n) sram[bus.sram_addr] = bus.sram_dq_out;

    function automatic logic [15:0] pat(input logic [17:0] a);
        return a[15:0] ^ {a[17:16], 14'h01A5};
    endfunction

    function automatic logic [31:0] ref_read(input logic [15:0] w);
        if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
        return {pat({1'b0, w, 1'b1}), pat({1'b0, w, 1'b0})};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(input bit is_mem, input bit rw, input logic [17:0] addr,
                              input logic [31:0] wd, output logic [31:0] data, output int lat);
        lat = 0;
        data = 'x;
        if (is_mem) begin
            bus.mem_mc_en = 1'b1; bus.mem_mc_rw = rw; bus.mem_mc_addr = addr; bus.mem_mc_wdata = wd;
        end else begin
            bus.if_mc_en = 1'b1; bus.if_mc_addr = addr;
        end
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (is_mem ? bus.mc_mem_done : bus.mc_if_valid) begin
                lat = c;
                data = is_mem ? bus.mc_mem_rdata : bus.mc_if_data;
                break;
            end
        end
        bus.mem_mc_en = 1'b0;
        bus.if_mc_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({bus.mc_if_data, bus.mc_mem_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_data if=%h rd=%h want 0", bus.mc_if_data, bus.mc_mem_rdata);
        end
        checks++;
        if ({bus.mc_if_valid, bus.mc_mem_done, bus.mc_stall, bus.sram_dq_oe} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {bus.mc_if_valid, bus.mc_mem_done, bus.mc_stall, bus.sram_dq_oe});
        end
        checks++;
        if ({bus.sram_addr, bus.sram_dq_out} !== 34'h0) begin
            errors++; $display("FAIL reset_sram_bus addr=%h dq=%h want 0", bus.sram_addr, bus.sram_dq_out);
        end
        checks++;
        if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n} !== 5'b11111) begin
            errors++; $display("FAIL reset_strobes got %b want 11111", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch(input logic [17:0] addr, input string name);
        bus.if_mc_en = 1'b1;
        bus.if_mc_addr = addr;
        tick();
        checks++;
        if ({bus.sram_addr, bus.mc_stall, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe} !== {18'h00004, 5'b10010}) begin
            errors++; $display("FAIL %s_lo addr=%h stall/ce/oe/we/oe=%b want 00004 10010", name, bus.sram_addr,
                               {bus.mc_stall, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe});
        end
        tick();
        checks++;
        if ({bus.sram_addr, bus.mc_stall, bus.mc_if_valid} !== {18'h00005, 2'b10}) begin
            errors++; $display("FAIL %s_hi addr=%h stall=%b valid=%b want 00005 1 0", name, bus.sram_addr, bus.mc_stall, bus.mc_if_valid);
        end
        tick();
        checks++;
        if ({bus.mc_if_valid, bus.mc_stall, bus.mc_if_data} !== {2'b10, 32'hDEADBEEF}) begin
            errors++; $display("FAIL %s_result valid=%b stall=%b data=%h want 1 0 deadbeef", name, bus.mc_if_valid, bus.mc_stall, bus.mc_if_data);
        end
        bus.if_mc_en = 1'b0;
        tick();
        checks++;
        if ({bus.mc_if_valid, bus.mc_stall, bus.sram_ce_n} !== 3'b001) begin
            errors++; $display("FAIL %s_after valid/stall/ce_n=%b want 001", name, {bus.mc_if_valid, bus.mc_stall, bus.sram_ce_n});
        end
        exp_if = 32'hDEADBEEF;
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        int lat;
        bus.mem_mc_en = 1'b1; bus.mem_mc_rw = 1'b1; bus.mem_mc_addr = 18'h00100; bus.mem_mc_wdata = 32'h12345678;
        tick();
        checks++;
        if ({bus.sram_addr, bus.sram_dq_out, bus.sram_dq_oe, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n} !== {18'h00080, 16'h5678, 4'b1010}) begin
            errors++; $display("FAIL write_lo addr=%h dq=%h oe/ce/oe_n/we_n=%b want 00080 5678 1010", bus.sram_addr, bus.sram_dq_out,
                               {bus.sram_dq_oe, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n});
        end
        tick();
        checks++;
        if ({bus.sram_addr, bus.sram_dq_out, bus.sram_we_n} !== {18'h00081, 16'h1234, 1'b0}) begin
            errors++; $display("FAIL write_hi addr=%h dq=%h we_n=%b want 00081 1234 0", bus.sram_addr, bus.sram_dq_out, bus.sram_we_n);
        end
        tick();
        checks++;
        if ({bus.mc_mem_done, bus.sram_we_n, bus.mc_mem_rdata} !== {2'b11, exp_rd}) begin
            errors++; $display("FAIL write_done done=%b we_n=%b rdata=%h want 1 1 %h", bus.mc_mem_done, bus.sram_we_n, bus.mc_mem_rdata, exp_rd);
        end
        bus.mem_mc_en = 1'b0;
        tick();
        ref_mem[16'h0040] = 32'h12345678;
        run_access(1'b1, 1'b0, 18'h00100, 32'h0, d, lat);
        checks++;
        if (lat !== 3 || d !== 32'h12345678) begin
            errors++; $display("FAIL read_back lat=%0d data=%h want 3 12345678", lat, d);
        end
        exp_rd = 32'h12345678;
    endtask

    task automatic test_simultaneous();
        int lm = 0, lf = 0;
        logic [31:0] dm = 'x, df = 'x;
        bus.mem_mc_en = 1'b1; bus.mem_mc_rw = 1'b0; bus.mem_mc_addr = 18'h00100;
        bus.if_mc_en = 1'b1; bus.if_mc_addr = 18'h00204;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.mc_mem_done && lm == 0) begin lm = c; dm = bus.mc_mem_rdata; bus.mem_mc_en = 1'b0; end
            if (bus.mc_if_valid && lf == 0) begin lf = c; df = bus.mc_if_data; bus.if_mc_en = 1'b0; end
        end
        bus.mem_mc_en = 1'b0; bus.if_mc_en = 1'b0;
        checks++;
        if (lm !== 3 || dm !== 32'h12345678) begin
            errors++; $display("FAIL simul_mem lat=%0d data=%h want 3 12345678", lm, dm);
        end
        checks++;
        if (lf !== 6 || df !== ref_read(16'h0081)) begin
            errors++; $display("FAIL simul_fetch lat=%0d data=%h want 6 %h", lf, df, ref_read(16'h0081));
        end
        exp_if = ref_read(16'h0081);
    endtask

    task automatic test_reset_mid();
        bus.mem_mc_en = 1'b1; bus.mem_mc_rw = 1'b1; bus.mem_mc_addr = 18'h3F000; bus.mem_mc_wdata = 32'hCAFEF00D;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe, bus.mc_stall, bus.sram_addr} !== {5'b11100, 18'h0}) begin
            errors++; $display("FAIL reset_mid_strobes ce/we/oe/dqoe/stall=%b addr=%h want 11100 0",
                               {bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe, bus.mc_stall}, bus.sram_addr);
        end
        bus.mem_mc_en = 1'b0;
        tick();
        checks++;
        if (bus.mc_mem_done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_done got %b want 0", bus.mc_mem_done);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.mc_mem_done, bus.mc_if_valid, bus.mc_stall, bus.sram_ce_n, bus.mc_if_data, bus.mc_mem_rdata} !== {4'b0001, 64'h0}) begin
            errors++; $display("FAIL reset_mid_after done/valid/stall/ce=%b if=%h rd=%h want 0001 0 0",
                               {bus.mc_mem_done, bus.mc_if_valid, bus.mc_stall, bus.sram_ce_n}, bus.mc_if_data, bus.mc_mem_rdata);
        end
        exp_if = '0;
        exp_rd = '0;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if ({bus.sram_ce_n, bus.mc_stall, bus.mc_if_valid, bus.mc_mem_done} !== 4'b1000) begin
                errors++; $display("FAIL idle_%0d ce/stall/valid/done=%b want 1000", c,
                                   {bus.sram_ce_n, bus.mc_stall, bus.mc_if_valid, bus.mc_mem_done});
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d, wd, want;
        logic [15:0] w;
        int lat, kind;
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            w = 16'h0080 + 16'($urandom_range(0, 31));
            wd = $urandom;
            want = ref_read(w);
            run_access(kind != 0, kind == 2, {w, 2'($urandom_range(0, 3))}, wd, d, lat);
            checks++;
            if (lat !== 3) begin
                errors++; $display("FAIL rand_%0d_latency kind=%0d got %0d want 3", i, kind, lat);
            end
            if (kind == 2) ref_mem[int'(w)] = wd;
            else begin
                checks++;
                if (d !== want) begin
                    errors++; $display("FAIL rand_%0d_data kind=%0d word=%h got %h want %h", i, kind, w, d, want);
                end
                if (kind == 0) exp_if = want;
                else exp_rd = want;
            end
            checks++;
            if (bus.mc_if_data !== exp_if || bus.mc_mem_rdata !== exp_rd) begin
                errors++; $display("FAIL rand_%0d_hold if=%h rd=%h want %h %h", i, bus.mc_if_data, bus.mc_mem_rdata, exp_if, exp_rd);
            end
        end
    endtask

    initial begin
        bus.if_mc_en = 1'b0; bus.if_mc_addr = '0;
        bus.mem_mc_en = 1'b0; bus.mem_mc_rw = 1'b0; bus.mem_mc_addr = '0; bus.mem_mc_wdata = '0;
        for (int i = 0; i < 262144; i++) sram[i] = pat(18'(i));
        sram[4] = 16'hBEEF;
        sram[5] = 16'hDEAD;
        ref_mem[2] = 32'hDEADBEEF;
        test_reset();
        test_fetch(18'h00008, "fetch");
        test_fetch(18'h0000B, "fetch_lsb");
        test_write_read();
        test_simultaneous();
        test_reset_mid();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
